// File: rtl/id_pkg.sv
// Shared decode definitions for the instruction-decode stage: opcodes,
// ALUOp codes, the control-bit bundle and register-file geometry.
package id_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,  // address generation for lw/sw
        ALU_SUB   = 2'b01,  // beq compare
        ALU_FUNCT = 2'b10,  // R-type, ALU looks at funct
        ALU_IMM   = 2'b11   // immediate arithmetic/logic
    } alu_op_e;

    typedef struct packed {
        logic    reg_write;
        logic    mem_to_reg;
        logic    branch;
        logic    mem_read;
        logic    mem_write;
        logic    reg_dst;
        logic    alu_src;
        alu_op_e alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        reg_write:  1'b0,
        mem_to_reg: 1'b0,
        branch:     1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        reg_dst:    1'b0,
        alu_src:    1'b0,
        alu_op:     ALU_ADD
    };

    // andi/ori are the logical-immediate ops that may zero-extend.
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// IF/ID inputs, write-back port and ID/EX payload of the decode stage,
// bundled so the stage and its neighbours connect through one port.
interface id_stage_pipe_if #(
    parameter int B = 32
);
    // IF/ID side and control
    logic         in_valid;
    logic [31:0]  instruction;
    logic [B-1:0] pc_plus4_in;
    logic         flush;
    logic         stall_out;

    // write-back port
    logic         wb_reg_write;
    logic [4:0]   wb_addr;
    logic [B-1:0] wb_data;

    // ID/EX payload
    logic         valid_out;
    logic [B-1:0] pc_plus4_out;
    logic [B-1:0] reg_data1;
    logic [B-1:0] reg_data2;
    logic [B-1:0] imm_ext;
    logic [4:0]   rs_out;
    logic [4:0]   rt_out;
    logic [4:0]   rd_out;
    logic         wb_RegWrite_out;
    logic         wb_MemtoReg_out;
    logic         m_Branch_out;
    logic         m_MemRead_out;
    logic         m_MemWrite_out;
    logic         ex_RegDst_out;
    logic         ex_ALUSrc_out;
    logic [1:0]   ex_ALUOp_out;
    logic         illegal_op_out;

    modport master (
        output in_valid, instruction, pc_plus4_in, flush,
               wb_reg_write, wb_addr, wb_data,
        input  stall_out, valid_out, pc_plus4_out, reg_data1, reg_data2, imm_ext,
               rs_out, rt_out, rd_out,
               wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
               m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out,
               illegal_op_out
    );

    modport slave (
        input  in_valid, instruction, pc_plus4_in, flush,
               wb_reg_write, wb_addr, wb_data,
        output stall_out, valid_out, pc_plus4_out, reg_data1, reg_data2, imm_ext,
               rs_out, rt_out, rd_out,
               wb_RegWrite_out, wb_MemtoReg_out, m_Branch_out, m_MemRead_out,
               m_MemWrite_out, ex_RegDst_out, ex_ALUSrc_out, ex_ALUOp_out,
               illegal_op_out
    );

endinterface

// File: rtl/id_regfile.sv
// 32 x B register file: two combinational read ports with write-through
// bypass from the write port, register 0 hard-wired to zero.
module id_regfile
    import id_pkg::*;
#(
    parameter int B = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs_addr,
    input  logic [REG_AW-1:0] rt_addr,
    output logic [B-1:0]      rs_data,
    output logic [B-1:0]      rt_data,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [B-1:0]      wd
);

    logic [B-1:0] regs [NUM_REGS];

    // The write data is visible to readers in the same cycle it is written.
    function automatic logic [B-1:0] read_port(input logic [REG_AW-1:0] addr);
        if (addr == '0) begin
            return '0;
        end else if (we && (wa == addr)) begin
            return wd;
        end else begin
            return regs[addr];
        end
    endfunction

    assign rs_data = read_port(rs_addr);
    assign rt_data = read_port(rt_addr);

    // NOTE: the array is reset because every entry must read 0 while reset
    // is low; that keeps it as flops, which is fine at 32 entries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS instruction-decode stage: register read, control decode, immediate
// extension, load-use stall detection and the ID/EX pipeline register.
module id_stage_pipe
    import id_pkg::*;
#(
    parameter int B        = 32,
    parameter bit IMM_ZEXT = 1'b1
) (
    input logic           clk,
    input logic           reset,
    id_stage_pipe_if.slave bus
);

    typedef struct packed {
        logic              valid;
        ctrl_t             ctrl;
        logic              illegal;
        logic [B-1:0]      pc_plus4;
        logic [B-1:0]      data1;
        logic [B-1:0]      data2;
        logic [B-1:0]      imm;
        logic [REG_AW-1:0] rs;
        logic [REG_AW-1:0] rt;
        logic [REG_AW-1:0] rd;
    } idex_t;

    logic [5:0]        op;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    logic [15:0]       imm16;

    assign op    = bus.instruction[31:26];
    assign rs    = bus.instruction[25:21];
    assign rt    = bus.instruction[20:16];
    assign rd    = bus.instruction[15:11];
    assign imm16 = bus.instruction[15:0];

    logic [B-1:0] rs_data;
    logic [B-1:0] rt_data;

    id_regfile #(.B(B)) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (bus.wb_reg_write),
        .wa      (bus.wb_addr),
        .wd      (bus.wb_data)
    );

    ctrl_t ctrl;
    logic  illegal;

    // NOTE: every output gets a default first so no path through the case
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ctrl    = CTRL_NONE;
        illegal = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            OP_BEQ: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_IMM;
            end
            default: illegal = 1'b1;
        endcase
    end

    logic [B-1:0] imm_ext_c;

    // Casting through signed'() sign-extends without a zero-width replication at B=16.
    assign imm_ext_c = (IMM_ZEXT && is_logic_imm(op)) ? B'(imm16) : B'(signed'(imm16));

    idex_t q;
    idex_t d;
    logic  hazard;
    logic  bubble;

    // The hazard compares against the load already sitting in ID/EX.
    assign hazard = bus.in_valid & q.valid & q.ctrl.mem_read & (q.rt != '0)
                  & ((q.rt == rs) | (q.rt == rt));
    assign bus.stall_out = hazard & ~bus.flush;
    assign bubble        = bus.stall_out | bus.flush | ~bus.in_valid;

    always_comb begin
        d          = '0;
        d.valid    = 1'b1;
        d.ctrl     = ctrl;
        d.illegal  = illegal;
        d.pc_plus4 = bus.pc_plus4_in;
        d.data1    = rs_data;
        d.data2    = rt_data;
        d.imm      = imm_ext_c;
        d.rs       = rs;
        d.rt       = rt;
        d.rd       = rd;
    end

    // NOTE: non-blocking assignment for all sequential state so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

    assign bus.valid_out       = q.valid;
    assign bus.pc_plus4_out    = q.pc_plus4;
    assign bus.reg_data1       = q.data1;
    assign bus.reg_data2       = q.data2;
    assign bus.imm_ext         = q.imm;
    assign bus.rs_out          = q.rs;
    assign bus.rt_out          = q.rt;
    assign bus.rd_out          = q.rd;
    assign bus.wb_RegWrite_out = q.ctrl.reg_write;
    assign bus.wb_MemtoReg_out = q.ctrl.mem_to_reg;
    assign bus.m_Branch_out    = q.ctrl.branch;
    assign bus.m_MemRead_out   = q.ctrl.mem_read;
    assign bus.m_MemWrite_out  = q.ctrl.mem_write;
    assign bus.ex_RegDst_out   = q.ctrl.reg_dst;
    assign bus.ex_ALUSrc_out   = q.ctrl.alu_src;
    assign bus.ex_ALUOp_out    = q.ctrl.alu_op;
    assign bus.illegal_op_out  = q.illegal;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed scenarios followed by
// random traffic, all compared against a behavioural decode-stage model.
module tb_id_stage_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.B(32)) bus ();

    id_stage_pipe #(.B(32), .IMM_ZEXT(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ctrl bit order: RegWrite MemtoReg Branch MemRead MemWrite RegDst ALUSrc ALUOp[1:0]
    typedef struct packed {
        logic        valid;
        logic [8:0]  ctrl;
        logic        ill;
        logic [31:0] pc;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    logic [31:0] mregs [32];
    exp_t        ev;
    logic        last_stall;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd);
        return {6'b000000, rs, rt, rd, 5'd0, 6'h20};
    endfunction

    // Register value as seen by a reader this cycle, including the write-through path.
    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wa == a) return wd;
        return mregs[a];
    endfunction

    function automatic logic [9:0] model_decode(input logic [5:0] op);
        case (op)
            6'h00:               return {9'b1_0_0_0_0_1_0_10, 1'b0};
            6'h23:               return {9'b1_1_0_1_0_0_1_00, 1'b0};
            6'h2b:               return {9'b0_0_0_0_1_0_1_00, 1'b0};
            6'h04:               return {9'b0_0_1_0_0_0_0_01, 1'b0};
            6'h08, 6'h0c, 6'h0d: return {9'b1_0_0_0_0_0_1_11, 1'b0};
            default:             return {9'b0, 1'b1};
        endcase
    endfunction

    task automatic check_outputs();
        chk("valid", bus.valid_out, ev.valid);
        chk("ctrl", {bus.wb_RegWrite_out, bus.wb_MemtoReg_out, bus.m_Branch_out,
                     bus.m_MemRead_out, bus.m_MemWrite_out, bus.ex_RegDst_out,
                     bus.ex_ALUSrc_out, bus.ex_ALUOp_out}, ev.ctrl);
        chk("illegal", bus.illegal_op_out, ev.ill);
        chk("pc", bus.pc_plus4_out, ev.pc);
        chk("rd1", bus.reg_data1, ev.d1);
        chk("rd2", bus.reg_data2, ev.d2);
        chk("imm", bus.imm_ext, ev.imm);
        chk("fields", {bus.rs_out, bus.rt_out, bus.rd_out}, {ev.rs, ev.rt, ev.rd});
    endtask

    // One pipeline cycle: drive inputs, check stall, clock, check ID/EX.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic fl);
        exp_t       nx;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       exp_stall;
        logic [9:0] dec;
        logic [5:0] op;
        bus.in_valid     = v;
        bus.instruction  = ins;
        bus.pc_plus4_in  = pc;
        bus.wb_reg_write = we;
        bus.wb_addr      = wa;
        bus.wb_data      = wd;
        bus.flush        = fl;
        #1;
        op = ins[31:26];
        rs = ins[25:21];
        rt = ins[20:16];
        exp_stall = v && ev.valid && ev.ctrl[5] && ev.rt != 0 && (ev.rt == rs || ev.rt == rt) && !fl;
        chk("stall", bus.stall_out, exp_stall);
        last_stall = exp_stall;
        nx = '0;
        if (v && !fl && !exp_stall) begin
            dec      = model_decode(op);
            nx.valid = 1'b1;
            nx.ctrl  = dec[9:1];
            nx.ill   = dec[0];
            nx.pc    = pc;
            nx.d1    = model_read(rs, we, wa, wd);
            nx.d2    = model_read(rt, we, wa, wd);
            nx.imm   = (op == 6'h0c || op == 6'h0d) ? {16'h0, ins[15:0]}
                                                    : {{16{ins[15]}}, ins[15:0]};
            nx.rs    = rs;
            nx.rt    = rt;
            nx.rd    = ins[15:11];
        end
        @(posedge clk);
        #1;
        if (we && wa != 0) mregs[wa] = wd;
        ev = nx;
        check_outputs();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] ins;
        logic [5:0]  ops [8];
        logic [31:0] r_pc;
        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h3f};
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        ev = '0;
        last_stall = 1'b0;
        bus.in_valid = 1'b0; bus.instruction = '0; bus.pc_plus4_in = '0; bus.flush = 1'b0;
        bus.wb_reg_write = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b1;

        // Write r5 via WB, then add r1,r5,r5
        step(1'b0, 32'h0, 32'h0, 1'b1, 5'd5, 32'h1234, 1'b0);
        step(1'b1, mk_r(5'd5, 5'd5, 5'd1), 32'h104, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("add_rd1", bus.reg_data1, 32'h1234);
        chk("add_rd2", bus.reg_data2, 32'h1234);
        chk("add_aluop", bus.ex_ALUOp_out, 2'b10);
        chk("add_regdst", bus.ex_RegDst_out, 1'b1);

        // Same-cycle write-through for sw r7; r0 ignores writes
        step(1'b1, mk_i(6'h2b, 5'd5, 5'd7, 16'h0010), 32'h108, 1'b1, 5'd7, 32'hBEEF, 1'b0);
        chk("sw_bypass", bus.reg_data2, 32'hBEEF);
        step(1'b1, mk_r(5'd0, 5'd7, 5'd2), 32'h10c, 1'b1, 5'd0, 32'hFFFF, 1'b0);
        chk("r0_same", bus.reg_data1, 32'h0);
        step(1'b1, mk_r(5'd0, 5'd0, 5'd2), 32'h110, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("r0_after", bus.reg_data1, 32'h0);

        // Load-use: lw r3,0(r2); add r4,r3,r1 stalls one cycle then issues
        step(1'b1, mk_i(6'h23, 5'd2, 5'd3, 16'h0000), 32'h114, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, mk_r(5'd3, 5'd1, 5'd4), 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_stall_seen", last_stall, 1'b1);
        chk("lu_bubble", bus.valid_out, 1'b0);
        step(1'b1, mk_r(5'd3, 5'd1, 5'd4), 32'h118, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("lu_nostall", last_stall, 1'b0);
        chk("lu_issue", bus.valid_out, 1'b1);

        // Load-use with flush: flush wins, no stall, bubble
        step(1'b1, mk_i(6'h23, 5'd2, 5'd3, 16'h0004), 32'h11c, 1'b0, 5'd0, 32'h0, 1'b0);
        step(1'b1, mk_r(5'd1, 5'd3, 5'd4), 32'h120, 1'b0, 5'd0, 32'h0, 1'b1);
        chk("fl_nostall", last_stall, 1'b0);
        chk("fl_bubble", bus.valid_out, 1'b0);

        // Immediate extension and illegal opcode
        step(1'b1, mk_i(6'h0d, 5'd1, 5'd2, 16'h8000), 32'h124, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("ori_zext", bus.imm_ext, 32'h0000_8000);
        step(1'b1, mk_i(6'h08, 5'd1, 5'd2, 16'h8000), 32'h128, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("addi_sext", bus.imm_ext, 32'hFFFF_8000);
        step(1'b1, mk_i(6'h3f, 5'd1, 5'd2, 16'h1234), 32'h12c, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("ill_flag", bus.illegal_op_out, 1'b1);
        chk("ill_ctrl", {bus.wb_RegWrite_out, bus.m_MemRead_out, bus.m_MemWrite_out,
                         bus.ex_ALUSrc_out, bus.ex_ALUOp_out}, 6'b0);

        // Random traffic; a stalled instruction is held in IF/ID like real fetch
        ins = 32'h0;
        r_pc = 32'h200;
        for (int n = 0; n < 400; n++) begin
            logic v;
            logic fl;
            if (!last_stall) begin
                ins = mk_i(ops[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 16'($urandom()));
                r_pc = r_pc + 32'd4;
            end
            v  = ($urandom_range(0, 9) != 0);
            fl = ($urandom_range(0, 11) == 0);
            step(v, ins, r_pc, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                 $urandom(), fl);
        end

        // Asynchronous reset mid-stream with a valid instruction in ID/EX
        step(1'b1, mk_i(6'h08, 5'd5, 5'd7, 16'h0001), 32'h300, 1'b1, 5'd5, 32'h5555, 1'b0);
        chk("pre_rst_valid", bus.valid_out, 1'b1);
        #2;
        reset = 1'b0;
        bus.wb_reg_write = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'hDEAD;
        #1;
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        ev = '0;
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        bus.wb_reg_write = 1'b0;
        reset = 1'b1;
        step(1'b1, mk_r(5'd5, 5'd7, 5'd1), 32'h304, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("post_rst_r5", bus.reg_data1, 32'h0);
        chk("post_rst_r7", bus.reg_data2, 32'h0);
        step(1'b1, mk_r(5'd9, 5'd1, 5'd1), 32'h308, 1'b0, 5'd0, 32'h0, 1'b0);
        chk("post_rst_r9", bus.reg_data1, 32'h0);
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
